// File: rtl/div4_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div4_stream_ctrl
// Purpose  : Valid/ready streaming wrapper around a 4b/2b combinational divider
//            with a 4-entry operand FIFO, issue and output registers.
// Revision : 1.0 - initial release
// ============================================================================
module div4_stream_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [1:0] in_b,
    output logic [3:0] div_a,
    output logic [1:0] div_b,
    input  logic [3:0] div_q,
    input  logic [3:0] div_r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_q,
    output logic [3:0] out_r,
    output logic       out_dz,
    output logic [1:0] out_tag,
    output logic [7:0] dz_count
);

    localparam logic [2:0] c_full_count = 3'(DEPTH);

    logic [3:0] r_fifo_a   [4];
    logic [1:0] r_fifo_b   [4];
    logic [1:0] r_fifo_tag [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic [1:0] r_seq;

    logic       r_s1_valid;
    logic [3:0] r_s1_a;
    logic [1:0] r_s1_b;
    logic [1:0] r_s1_tag;

    logic       r_s2_valid;
    logic [3:0] r_s2_q;
    logic [3:0] r_s2_r;
    logic       r_s2_dz;
    logic [1:0] r_s2_tag;
    logic [7:0] r_dz_count;

    logic w_accept;
    logic w_adv1;
    logic w_adv2;
    logic w_fifo_empty;
    logic w_pop;
    logic w_bypass;
    logic w_push;

    // in_ready depends on the FIFO count only, never on out_ready.
    assign in_ready     = (r_count != c_full_count);
    assign w_accept     = in_valid && in_ready;
    assign w_adv2       = !r_s2_valid || out_ready;
    assign w_adv1       = !r_s1_valid || w_adv2;
    assign w_fifo_empty = (r_count == 3'd0);
    assign w_pop        = w_adv1 && !w_fifo_empty;
    assign w_bypass     = w_adv1 && w_fifo_empty && w_accept;
    assign w_push       = w_accept && !w_bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo_a[i]   <= 4'd0;
                r_fifo_b[i]   <= 2'd0;
                r_fifo_tag[i] <= 2'd0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_seq    <= 2'd0;
        end else begin
            if (w_accept) begin
                r_seq <= r_seq + 2'd1;
            end
            if (w_push) begin
                r_fifo_a[r_wr_ptr]   <= in_a;
                r_fifo_b[r_wr_ptr]   <= in_b;
                r_fifo_tag[r_wr_ptr] <= r_seq;
                r_wr_ptr             <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    // Issue stage: FIFO head has priority; an empty FIFO lets the input bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 4'd0;
            r_s1_b     <= 2'd0;
            r_s1_tag   <= 2'd0;
        end else if (w_adv1) begin
            if (w_pop) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= r_fifo_a[r_rd_ptr];
                r_s1_b     <= r_fifo_b[r_rd_ptr];
                r_s1_tag   <= r_fifo_tag[r_rd_ptr];
            end else if (w_bypass) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_tag   <= r_seq;
            end else begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Output stage: a zero divisor forces a saturated quotient and passes a through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_q     <= 4'd0;
            r_s2_r     <= 4'd0;
            r_s2_dz    <= 1'b0;
            r_s2_tag   <= 2'd0;
        end else if (w_adv2) begin
            if (r_s1_valid) begin
                r_s2_valid <= 1'b1;
                r_s2_tag   <= r_s1_tag;
                if (r_s1_b == 2'd0) begin
                    r_s2_q  <= 4'hF;
                    r_s2_r  <= r_s1_a;
                    r_s2_dz <= 1'b1;
                end else begin
                    r_s2_q  <= div_q;
                    r_s2_r  <= div_r;
                    r_s2_dz <= 1'b0;
                end
            end else begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dz_count <= 8'd0;
        end else if (r_s2_valid && out_ready && r_s2_dz) begin
            r_dz_count <= r_dz_count + 8'd1;
        end
    end

    assign div_a     = r_s1_a;
    assign div_b     = r_s1_b;
    assign out_valid = r_s2_valid;
    assign out_q     = r_s2_q;
    assign out_r     = r_s2_r;
    assign out_dz    = r_s2_dz;
    assign out_tag   = r_s2_tag;
    assign dz_count  = r_dz_count;

endmodule
`default_nettype wire

// File: tb/tb_div4_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div4_stream_ctrl
// Purpose  : Directed and randomized scoreboard bench for div4_stream_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div4_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [1:0] in_b;
    logic [3:0] div_a;
    logic [1:0] div_b;
    logic [3:0] div_q;
    logic [3:0] div_r;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_q;
    logic [3:0] out_r;
    logic       out_dz;
    logic [1:0] out_tag;
    logic [7:0] dz_count;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;

    // Expected entry: {q[3:0], r[3:0], dz, tag[1:0]}
    logic [10:0] sb [$];
    logic [1:0]  m_seq;
    logic [7:0]  m_dz;
    logic        prev_stall;
    logic [10:0] saved;

    div4_stream_ctrl #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_q    (div_q),
        .div_r    (div_r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q    (out_q),
        .out_r    (out_r),
        .out_dz   (out_dz),
        .out_tag  (out_tag),
        .dz_count (dz_count)
    );

    // Divider stand-in; junk on a zero divisor so an un-overridden result shows up.
    assign div_q = (div_b == 2'd0) ? 4'hA : 4'(div_a / {2'b00, div_b});
    assign div_r = (div_b == 2'd0) ? 4'h5 : 4'(div_a % {2'b00, div_b});

    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [3:0] a, input logic [1:0] b,
                                          input logic [1:0] tag);
        logic [3:0] q;
        logic [3:0] r;
        if (b == 2'd0) return {4'hF, a, 1'b1, tag};
        q = 4'd0;
        r = a;
        while (r >= {2'b00, b}) begin
            r = r - {2'b00, b};
            q = q + 4'd1;
        end
        return {q, r, 1'b0, tag};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        m_seq      = 2'd0;
        m_dz       = 8'd0;
        prev_stall = 1'b0;
        saved      = 11'd0;
    endtask

    // Observe one cycle at the falling edge, then advance past the next rising edge.
    task automatic cycle();
        logic [10:0] e;
        @(negedge clk);
        check("dz_count", 32'(dz_count), 32'(m_dz));
        if (prev_stall)
            check("stall_hold", {out_valid, out_q, out_r, out_dz, out_tag}, {1'b1, saved});
        if (in_valid && in_ready) begin
            sb.push_back(model(in_a, in_b, m_seq));
            m_seq = m_seq + 2'd1;
            accepts++;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", {out_q, out_r, out_dz, out_tag}, 32'(e));
                if (e[2]) m_dz = m_dz + 8'd1;
            end
        end
        prev_stall = out_valid && !out_ready;
        saved      = {out_q, out_r, out_dz, out_tag};
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 2'd0;
        out_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_q",     32'(out_q),     32'd0);
        check("rst_out_r",     32'(out_r),     32'd0);
        check("rst_out_dz",    32'(out_dz),    32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_div_a",     32'(div_a),     32'd0);
        check("rst_div_b",     32'(div_b),     32'd0);
        check("rst_dz_count",  32'(dz_count),  32'd0);
        rst = 1'b0;

        // Single op on an idle block: 13 / 3
        in_valid = 1'b1; in_a = 4'd13; in_b = 2'd3; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("single_div_a", 32'(div_a), 32'd13);
        cycle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_out", {out_q, out_r, out_dz, out_tag}, {4'd4, 4'd1, 1'b0, 2'd0});
        cycle();
        check("single_done", 32'(out_valid), 32'd0);

        // Divide by zero: 9 / 0
        in_valid = 1'b1; in_a = 4'd9; in_b = 2'd0;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("dz_out", {out_valid, out_q, out_r, out_dz}, {1'b1, 4'hF, 4'd9, 1'b1});
        cycle();
        check("dz_count_one", 32'(dz_count), 32'd1);

        // Streaming 16 back-to-back pairs
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 2'((i % 3) + 1);
            cycle();
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (i >= 1) check("stream_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        check("stream_drain", 32'(sb.size()), 32'd0);

        // Fill under backpressure: exactly six accepts
        accepts   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = 4'($urandom); in_b = 2'($urandom);
            cycle();
        end
        check("full_accepts", 32'(accepts), 32'd6);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("in_ready_rise", 32'(in_ready), 32'd1);
        repeat (8) cycle();
        check("full_drain", 32'(sb.size()), 32'd0);

        // Random valid/ready toggling, 1000 pairs
        accepts = 0;
        guard   = 0;
        while (accepts < 1000 && guard < 20000) begin
            in_valid  = 1'($urandom);
            in_a      = 4'($urandom);
            in_b      = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        check("rand_accepts", 32'(accepts), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) cycle();
        check("rand_drain", 32'(sb.size()), 32'd0);

        // Reset with four pairs buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 4'(i + 4); in_b = 2'd0;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_dz_count",  32'(dz_count),  32'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1; in_a = 4'd7; in_b = 2'd2; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("post_rst_out", {out_valid, out_q, out_r, out_dz, out_tag},
              {1'b1, 4'd3, 4'd1, 1'b0, 2'd0});
        cycle();
        check("post_rst_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
